prog_fetch_unit: RTL and testbench

Parametrised, writable successor to the fixed program ROM. Stores NUM_PROGS independent programs of up to DEPTH instructions each. A loader port fills them at run time. A fetch sequencer streams a selected program, one instruction at a time, to the processor's decode stage over a valid/ready handshake. A per-program end marker replaces the old unpopulated-entry behaviour, and completion and errors are flagged explicitly.

---
 rtl/prog_fetch_unit.sv | 193 +++++++++++++++++++
 tb/tb_prog_fetch_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_fetch_unit.sv
// prog_fetch_unit: writable multi-slot program store with a valid/ready fetch sequencer.
// Define PROG_FETCH_LOOP_EN to let a run repeat its program until abort or reset.
module prog_fetch_unit #(
   parameter int INSTR_W   = 8,
   parameter int ADDR_W    = 8,
   parameter int DEPTH     = 256,
   parameter int NUM_PROGS = 4,
   parameter int PROG_W    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_en,
   input  logic [PROG_W-1:0]  load_prog,
   input  logic [ADDR_W-1:0]  load_addr,
   input  logic [INSTR_W-1:0] load_data,
   input  logic               load_last,
   input  logic               start,
   input  logic [PROG_W-1:0]  prog_sel,
   input  logic               abort,
   input  logic               loop_mode,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [ADDR_W-1:0]  pc,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int PI_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;
   localparam int AI_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
   localparam logic [PROG_W:0] PROG_LIM  = (PROG_W + 1)'(NUM_PROGS);
   localparam logic [ADDR_W-1:0] PC_ONE  = 1;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      PRESENT
   } state_t;

   logic [INSTR_W-1:0] r_mem [NUM_PROGS][DEPTH];
   logic [ADDR_W-1:0]  r_last [NUM_PROGS];
   logic [NUM_PROGS-1:0] r_lenValid;

   state_t             r_state;
   state_t             w_nextState;
   logic [PROG_W-1:0]  r_prog;
   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  w_pcNext;
   logic [INSTR_W-1:0] r_instr;
   logic               r_done;
   logic               r_err;

   logic [PI_W-1:0]    w_loadProgIdx;
   logic [AI_W-1:0]    w_loadAddrIdx;
   logic [PI_W-1:0]    w_selIdx;
   logic [PI_W-1:0]    w_progIdx;
   logic [AI_W-1:0]    w_pcIdx;
   logic               w_loadInRange;
   logic               w_loadHazard;
   logic               w_loadWe;
   logic               w_loadErr;
   logic               w_selInRange;
   logic               w_selReady;
   logic               w_startOk;
   logic               w_startErr;
   logic               w_accept;
   logic               w_isLast;
   logic               w_lastDone;
   logic               w_loop;

   assign w_loadProgIdx = load_prog[PI_W-1:0];
   assign w_loadAddrIdx = load_addr[AI_W-1:0];
   assign w_selIdx      = prog_sel[PI_W-1:0];
   assign w_progIdx     = r_prog[PI_W-1:0];
   assign w_pcIdx       = r_pc[AI_W-1:0];

   // A load is refused when it falls outside the array or targets the slot being streamed.
   assign w_loadInRange = ({1'b0, load_addr} < DEPTH_LIM) && ({1'b0, load_prog} < PROG_LIM);
   assign w_loadHazard  = (r_state != IDLE) && (load_prog == r_prog);
   assign w_loadWe      = load_en && w_loadInRange && !w_loadHazard;
   assign w_loadErr     = load_en && !(w_loadInRange && !w_loadHazard);

   assign w_selInRange  = ({1'b0, prog_sel} < PROG_LIM);
   assign w_selReady    = w_selInRange && r_lenValid[w_selIdx];
   assign w_startOk     = (r_state == IDLE) && start && w_selReady;
   assign w_startErr    = (r_state == IDLE) && start && !w_selReady;

   assign w_accept      = (r_state == PRESENT) && instr_ready && !abort;
   assign w_isLast      = (r_pc == r_last[w_progIdx]);
   assign w_lastDone    = w_accept && w_isLast;

`ifdef PROG_FETCH_LOOP_EN
   logic r_loop;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_loop <= 1'b0;
      end else if (w_startOk) begin
         r_loop <= loop_mode;
      end
   end

   assign w_loop = r_loop;
`else
   logic w_unusedLoopMode;

   assign w_unusedLoopMode = loop_mode;
   assign w_loop           = 1'b0;
`endif

   // Program storage and end markers are never reset; len_valid alone says a slot is usable.
   always_ff @(posedge clk) begin
      if (w_loadWe) begin
         r_mem[w_loadProgIdx][w_loadAddrIdx] <= load_data;
         if (load_last) begin
            r_last[w_loadProgIdx] <= load_addr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_prog     <= '0;
         r_pc       <= '0;
         r_instr    <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_lenValid <= '0;
      end else begin
         r_state <= w_nextState;
         r_pc    <= w_pcNext;
         r_done  <= w_lastDone;
         r_err   <= w_loadErr || w_startErr;
         if (w_startOk) begin
            r_prog <= prog_sel;
         end
         if (r_state == READ) begin
            r_instr <= r_mem[w_progIdx][w_pcIdx];
         end
         if (w_loadWe && load_last) begin
            r_lenValid[w_loadProgIdx] <= 1'b1;
         end
      end
   end

   // Abort takes priority over a handshake presented in the same cycle.
   always_comb begin
      w_nextState = r_state;
      w_pcNext    = r_pc;
      case (r_state)
         IDLE: begin
            if (w_startOk) begin
               w_nextState = READ;
               w_pcNext    = '0;
            end
         end
         READ: begin
            w_nextState = abort ? IDLE : PRESENT;
         end
         PRESENT: begin
            if (abort) begin
               w_nextState = IDLE;
            end else if (w_accept) begin
               if (w_isLast) begin
                  if (w_loop) begin
                     w_nextState = READ;
                     w_pcNext    = '0;
                  end else begin
                     w_nextState = IDLE;
                  end
               end else begin
                  w_nextState = READ;
                  w_pcNext    = r_pc + PC_ONE;
               end
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   assign instr       = r_instr;
   assign instr_valid = (r_state == PRESENT);
   assign pc          = r_pc;
   assign busy        = (r_state != IDLE);
   assign done        = r_done;
   assign err         = r_err;

endmodule

// File: tb/tb_prog_fetch_unit.sv
// Scoreboard testbench for prog_fetch_unit; expected instructions are queued at start and
// popped on each accepted handshake. Covers streaming, stalls, errors, hazards, abort and reset.
module tb_prog_fetch_unit;

   localparam int INSTR_W   = 8;
   localparam int ADDR_W    = 9;
   localparam int DEPTH     = 256;
   localparam int NUM_PROGS = 4;
   localparam int PROG_W    = 2;

   logic clk = 1'b0;
   logic rstN;
   logic loadEn;
   logic [PROG_W-1:0] loadProg;
   logic [ADDR_W-1:0] loadAddr;
   logic [INSTR_W-1:0] loadData;
   logic loadLast;
   logic startReq;
   logic [PROG_W-1:0] progSel;
   logic abortReq;
   logic loopMode;
   logic [INSTR_W-1:0] instr;
   logic instrValid;
   logic instrReady;
   logic [ADDR_W-1:0] pc;
   logic busy;
   logic done;
   logic err;

   int checks = 0;
   int failures = 0;
   int doneCount = 0;
   int base;

   logic [INSTR_W-1:0] model [NUM_PROGS][DEPTH];
   logic [ADDR_W+INSTR_W-1:0] expQ[$];
   logic [ADDR_W+INSTR_W-1:0] expItem;

   always #5 clk = ~clk;

   prog_fetch_unit #(
      .INSTR_W(INSTR_W),
      .ADDR_W(ADDR_W),
      .DEPTH(DEPTH),
      .NUM_PROGS(NUM_PROGS),
      .PROG_W(PROG_W)
   ) dut (
      .clk(clk),
      .rst_n(rstN),
      .load_en(loadEn),
      .load_prog(loadProg),
      .load_addr(loadAddr),
      .load_data(loadData),
      .load_last(loadLast),
      .start(startReq),
      .prog_sel(progSel),
      .abort(abortReq),
      .loop_mode(loopMode),
      .instr(instr),
      .instr_valid(instrValid),
      .instr_ready(instrReady),
      .pc(pc),
      .busy(busy),
      .done(done),
      .err(err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyLoad(input logic [PROG_W-1:0] p, input logic [ADDR_W-1:0] a,
                            input logic [INSTR_W-1:0] d, input logic last,
                            input logic expErr, input string tag);
      loadEn   = 1'b1;
      loadProg = p;
      loadAddr = a;
      loadData = d;
      loadLast = last;
      tick();
      loadEn   = 1'b0;
      loadLast = 1'b0;
      if (!expErr) model[p][a[7:0]] = d;
      checkOutput(tag, 32'(err), 32'(expErr));
   endtask

   task automatic applyStart(input logic [PROG_W-1:0] p, input logic loop);
      startReq = 1'b1;
      progSel  = p;
      loopMode = loop;
      tick();
      startReq = 1'b0;
      loopMode = 1'b0;
   endtask

   task automatic pushRun(input int p, input int n);
      for (int i = 0; i < n; i++) begin
         expQ.push_back({ADDR_W'(i), model[p][i]});
      end
   endtask

   task automatic waitIdle(input int maxCycles, input string tag);
      int n = 0;
      while (busy && n < maxCycles) begin
         tick();
         n++;
      end
      checkOutput(tag, 32'(busy), 32'd0);
      tick();
   endtask

   task automatic waitReadPc(input logic [ADDR_W-1:0] target, input string tag);
      int n = 0;
      while (!(busy && !instrValid && pc == target) && n < 40) begin
         tick();
         n++;
      end
      if (n >= 40) checkOutput(tag, 32'(pc), 32'(target));
   endtask

   // Every accepted handshake must match the next queued {pc, instr} in order.
   always @(negedge clk) begin
      if (done) doneCount++;
      if (instrValid && instrReady && !abortReq && rstN) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_accept_pc", 32'(pc), 32'hFFFF_FFFF);
         end else begin
            expItem = expQ.pop_front();
            checkOutput("stream_pc", 32'(pc), 32'(expItem[ADDR_W+INSTR_W-1:INSTR_W]));
            checkOutput("stream_instr", 32'(instr), 32'(expItem[INSTR_W-1:0]));
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rstN = 1'b0; loadEn = 1'b0; loadProg = '0; loadAddr = '0; loadData = '0;
      loadLast = 1'b0; startReq = 1'b0; progSel = '0; abortReq = 1'b0;
      loopMode = 1'b0; instrReady = 1'b1;
      tick();
      tick();
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_valid", 32'(instrValid), 32'd0);
      checkOutput("rst_pc", 32'(pc), 32'd0);
      checkOutput("rst_instr", 32'(instr), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      rstN = 1'b1;
      tick();

      // Basic run of slot 0 with the consumer always ready.
      applyLoad(2'd0, 9'd0, 8'h90, 1'b0, 1'b0, "t1_load0");
      applyLoad(2'd0, 9'd1, 8'hA4, 1'b0, 1'b0, "t1_load1");
      applyLoad(2'd0, 9'd2, 8'h21, 1'b0, 1'b0, "t1_load2");
      applyLoad(2'd0, 9'd3, 8'h80, 1'b1, 1'b0, "t1_load3");
      pushRun(0, 4);
      base = doneCount;
      applyStart(2'd0, 1'b0);
      checkOutput("t1_busy_n1", 32'(busy), 32'd1);
      checkOutput("t1_valid_n1", 32'(instrValid), 32'd0);
      tick();
      checkOutput("t1_valid_n2", 32'(instrValid), 32'd1);
      checkOutput("t1_first_instr", 32'(instr), 32'h90);
      waitIdle(40, "t1_idle");
      checkOutput("t1_done_count", 32'(doneCount - base), 32'd1);
      checkOutput("t1_done_width", 32'(done), 32'd0);
      checkOutput("t1_queue_empty", 32'(expQ.size()), 32'd0);

      // Consumer stalls for three cycles at pc 1.
      pushRun(0, 4);
      base = doneCount;
      applyStart(2'd0, 1'b0);
      waitReadPc(9'd1, "t2_wait_pc1");
      instrReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("t2_stall_valid", 32'(instrValid), 32'd1);
         checkOutput("t2_stall_instr", 32'(instr), 32'hA4);
         checkOutput("t2_stall_pc", 32'(pc), 32'd1);
      end
      instrReady = 1'b1;
      waitIdle(40, "t2_idle");
      checkOutput("t2_done_count", 32'(doneCount - base), 32'd1);
      checkOutput("t2_queue_empty", 32'(expQ.size()), 32'd0);

      // Start on an unloaded slot and an out-of-range load.
      startReq = 1'b1;
      progSel  = 2'd2;
      tick();
      startReq = 1'b0;
      checkOutput("t3_start_err", 32'(err), 32'd1);
      checkOutput("t3_start_busy", 32'(busy), 32'd0);
      tick();
      checkOutput("t3_err_width", 32'(err), 32'd0);
      applyLoad(2'd2, 9'd300, 8'h55, 1'b1, 1'b1, "t3_load_oob");
      startReq = 1'b1;
      progSel  = 2'd2;
      tick();
      startReq = 1'b0;
      checkOutput("t3_oob_no_len", 32'(err), 32'd1);
      checkOutput("t3_oob_busy", 32'(busy), 32'd0);

      // Loads during a run of slot 1: same slot refused, other slot accepted.
      applyLoad(2'd1, 9'd0, 8'h11, 1'b0, 1'b0, "t4_load0");
      applyLoad(2'd1, 9'd1, 8'h22, 1'b0, 1'b0, "t4_load1");
      applyLoad(2'd1, 9'd2, 8'h33, 1'b1, 1'b0, "t4_load2");
      pushRun(1, 3);
      base = doneCount;
      applyStart(2'd1, 1'b0);
      applyLoad(2'd1, 9'd2, 8'hFF, 1'b0, 1'b1, "t4_hazard_err");
      applyLoad(2'd3, 9'd0, 8'h5A, 1'b1, 1'b0, "t4_other_slot");
      waitIdle(40, "t4_idle");
      checkOutput("t4_done_count", 32'(doneCount - base), 32'd1);
      pushRun(3, 1);
      applyStart(2'd3, 1'b0);
      waitIdle(40, "t4_slot3_idle");
      checkOutput("t4_queue_empty", 32'(expQ.size()), 32'd0);

      // Abort while fetching pc 2.
      pushRun(0, 2);
      base = doneCount;
      applyStart(2'd0, 1'b0);
      waitReadPc(9'd2, "t5_wait_pc2");
      abortReq = 1'b1;
      tick();
      abortReq = 1'b0;
      checkOutput("t5_abort_busy", 32'(busy), 32'd0);
      checkOutput("t5_abort_valid", 32'(instrValid), 32'd0);
      tick();
      tick();
      checkOutput("t5_abort_no_done", 32'(doneCount - base), 32'd0);
      checkOutput("t5_queue_empty", 32'(expQ.size()), 32'd0);

      // Reset in the middle of a run of slot 1.
      pushRun(1, 1);
      base = doneCount;
      applyStart(2'd1, 1'b0);
      waitReadPc(9'd1, "t6_wait_pc1");
      rstN = 1'b0;
      tick();
      checkOutput("t6_rst_busy", 32'(busy), 32'd0);
      checkOutput("t6_rst_valid", 32'(instrValid), 32'd0);
      checkOutput("t6_rst_pc", 32'(pc), 32'd0);
      checkOutput("t6_rst_instr", 32'(instr), 32'd0);
      rstN = 1'b1;
      tick();
      tick();
      checkOutput("t6_no_done", 32'(doneCount - base), 32'd0);
      checkOutput("t6_queue_empty", 32'(expQ.size()), 32'd0);
      startReq = 1'b1;
      progSel  = 2'd0;
      tick();
      startReq = 1'b0;
      checkOutput("t6_stale_start_err", 32'(err), 32'd1);
      checkOutput("t6_stale_start_busy", 32'(busy), 32'd0);
      tick();

      // Two-entry program with loop_mode requested.
      applyLoad(2'd2, 9'd0, 8'hC3, 1'b0, 1'b0, "t7_load0");
      applyLoad(2'd2, 9'd1, 8'h3C, 1'b1, 1'b0, "t7_load1");
      base = doneCount;
`ifdef PROG_FETCH_LOOP_EN
      for (int r = 0; r < 3; r++) pushRun(2, 2);
      applyStart(2'd2, 1'b1);
      begin
         int n = 0;
         while ((doneCount - base) < 3 && n < 80) begin
            tick();
            n++;
         end
         if (n >= 80) checkOutput("t7_loop_timeout", 32'(doneCount - base), 32'd3);
      end
      checkOutput("t7_wrap_pc", 32'(pc), 32'd0);
      checkOutput("t7_wrap_busy", 32'(busy), 32'd1);
      abortReq = 1'b1;
      tick();
      abortReq = 1'b0;
      checkOutput("t7_abort_busy", 32'(busy), 32'd0);
      tick();
      checkOutput("t7_done_count", 32'(doneCount - base), 32'd3);
      checkOutput("t7_queue_empty", 32'(expQ.size()), 32'd0);
`else
      pushRun(2, 2);
      applyStart(2'd2, 1'b1);
      waitIdle(40, "t7_idle");
      checkOutput("t7_done_count", 32'(doneCount - base), 32'd1);
      checkOutput("t7_queue_empty", 32'(expQ.size()), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
